uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART receiver, 8N1 (1 start, 8 data LSB-first, 1 stop). Receive-side partner of UART_tx;
//  shares its baud setting. Synchronizes RX, oversamples mid-bit, presents a byte with sticky rdy.
//  Consumed by the command/response layer, which acks each byte with clr_rdy.
// PARAMETERS
//  BAUD_DIV  2604  clk cycles per bit (50 MHz / 19200 baud); must equal UART_tx's divisor, >= 4
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  RX           in   1  serial line, asynchronous to clk, idles high
//  clr_rdy      in   1  consumer ack; clears rdy
//  rx_data      out  8  last complete byte received
//  rdy          out  1  sticky byte-valid flag
//  framing_err  out  1  stop bit sampled low (only with UART_RX_FRAMING_ERR_EN)
// BEHAVIOUR
//  Reset (async, rst_n low): state=IDLE, sync flops=1 (line idle), baud_cnt=0, bit_cnt=0,
//   shift reg=9'h1FF, rx_data=8'h00, rdy=0, framing_err=0.
//  Sync: RX through 2 flops (rx_ff1 -> rx_ff2) before any use; logic sees rx_ff2 only.
//  FSM states: IDLE, START, RECV.
//   IDLE: rx_ff2==0 -> START; baud_cnt loads BAUD_DIV/2 (integer divide); bit_cnt=0; rdy cleared.
//   START: baud_cnt decrements; at 0 sample rx_ff2: 1 -> false start, back to IDLE, no flags change;
//     0 -> RECV, baud_cnt loads BAUD_DIV. Start bit is not shifted in.
//   RECV: baud_cnt decrements; at 0 shift rx_ff2 into MSB of 9-bit shifter (right shift),
//     bit_cnt++, reload BAUD_DIV. When the 9th sample (stop) lands: rx_data<=shifter[7:0]
//     (data bits), rdy<=1, go IDLE the next cycle.
//  Sampling: every bit sampled within +/-1 clk of its midpoint.
//  Latency: rdy rises 1 clk after the stop-bit sample, i.e. ~9.5*BAUD_DIV+3 clks after the RX fall.
//  rdy: set on frame completion; cleared by clr_rdy or by the IDLE->START transition.
//   Set and clr_rdy in same cycle -> set wins (rdy=1).
//  Overrun: new frame completing while rdy=1 overwrites rx_data; rdy stays 1; no error flag.
//  rx_data stable between completions; not cleared by clr_rdy or a new start bit.
//  Stop bit: not checked without the macro; frame is accepted regardless.
//  RX low held continuously (break): frame completes with 8'h00; FSM then sees low in IDLE
//   and restarts immediately; repeats for as long as the line stays low.
//  Reset mid-frame: everything returns to reset values immediately; the partial byte is discarded.
//  Counters: baud_cnt wide enough for BAUD_DIV ($clog2(BAUD_DIV+1)); bit_cnt 4 bits; no wrap past 9.
// CONFIGURATION
//  UART_RX_FRAMING_ERR_EN defined: framing_err port present; at stop sample, framing_err<=~rx_ff2,
//   updated every frame together with rdy; cleared with rdy by clr_rdy; byte and rdy still delivered.
//  Undefined: no framing_err port or logic; stop-bit value ignored.
// TESTING  (BAUD_DIV=16 for sim; loopback uses UART_tx with same divisor, TX->RX)
//  1 Reset, RX=1 idle 500 clks -> rdy=0, rx_data=8'h00 throughout.
//  2 Loopback UART_tx sends 8'hAA, then 8'hCC, then 8'h88 -> rdy rises, rx_data matches each byte;
//    clr_rdy pulse between bytes drops rdy next clk.
//  3 RX low 5 clks then high (glitch < BAUD_DIV/2) -> FSM returns to IDLE; rdy, rx_data unchanged.
//  4 Two frames 8'h55 then 8'h3C with no clr_rdy -> rdy stays 1, rx_data=8'h3C.
//  5 rst_n low midway through frame 8'hF0 -> outputs reset immediately; next frame 8'h0F received intact.
//  6 With UART_RX_FRAMING_ERR_EN: drive 8'h81 with stop bit low -> rdy=1, rx_data=8'h81, framing_err=1;
//    next good frame -> framing_err=0.

Source files
------------

// File: rtl/uart_rx.sv
// Purpose : 8N1 UART receiver; 2-flop RX synchronizer, mid-bit sampling, sticky byte-valid flag.
// Latency : rdy rises about 9.5*BAUD_DIV+3 clk after the RX falling edge of the start bit.
// Backpres: none on the line; an unacknowledged byte is overwritten by the next frame (rdy stays 1).
// Optional: define UART_RX_FRAMING_ERR_EN to add the framing_err output (stop bit sampled low).
module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
`ifdef UART_RX_FRAMING_ERR_EN
    ,
    output logic       framing_err
`endif
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [3:0]       STOP_IDX = 4'd8;

    // The half-bit load must leave at least one count before the sample point.
    generate
        if (BAUD_DIV < 4) begin : g_bad_div
            $error("uart_rx: BAUD_DIV must be >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RECV  = 2'd2
    } state_t;

    // Synchronizer; only rx_ff2 is used by the receive logic.
    logic rx_ff1;
    logic rx_ff2;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_nxt;
    logic [3:0]       bit_cnt;
    logic [3:0]       bit_cnt_nxt;
    logic [8:0]       shifter;
    logic [8:0]       shifter_nxt;
    logic [7:0]       rx_data_nxt;
    logic             rdy_nxt;

    // Sample point is the last count of each period, so every bit lasts exactly BAUD_DIV clocks
    // after the reload and the sample drifts by nothing over the frame.
    logic baud_tick;
    // Frame completes this cycle (stop bit sampled).
    logic frame_done;
    // Receiver leaves IDLE on a falling line; a pending byte flag is dropped here.
    logic start_det;

    // After nine right shifts the oldest bit falls off the LSB; it is never needed.
    logic unused_shift_lsb;
    assign unused_shift_lsb = shifter[0];

    assign baud_tick = (baud_cnt == CNT_LAST);

    // Bring the asynchronous line into the clk domain; reset to the idle (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1 <= 1'b1;
            rx_ff2 <= 1'b1;
        end else begin
            rx_ff1 <= RX;
            rx_ff2 <= rx_ff1;
        end
    end

    // Receive FSM: next state, bit timing and shift register updates.
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_cnt_nxt  = bit_cnt;
        shifter_nxt  = shifter;
        rx_data_nxt  = rx_data;
        frame_done   = 1'b0;
        start_det    = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_ff2) begin
                    state_nxt    = START;
                    baud_cnt_nxt = CNT_HALF;
                    bit_cnt_nxt  = 4'd0;
                    start_det    = 1'b1;
                end
            end

            START: begin
                if (baud_tick) begin
                    if (rx_ff2) begin
                        // Line went back high before mid start bit: treat as a glitch.
                        state_nxt    = IDLE;
                        baud_cnt_nxt = CNT_ZERO;
                    end else begin
                        state_nxt    = RECV;
                        baud_cnt_nxt = CNT_FULL;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt - CNT_LAST;
                end
            end

            RECV: begin
                if (baud_tick) begin
                    shifter_nxt  = {rx_ff2, shifter[8:1]};
                    bit_cnt_nxt  = bit_cnt + 4'd1;
                    baud_cnt_nxt = CNT_FULL;
                    if (bit_cnt == STOP_IDX) begin
                        // Ninth sample is the stop bit; the eight data bits sit just below it.
                        rx_data_nxt  = shifter[8:1];
                        frame_done   = 1'b1;
                        state_nxt    = IDLE;
                        baud_cnt_nxt = CNT_ZERO;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt - CNT_LAST;
                end
            end

            default: begin
                state_nxt    = IDLE;
                baud_cnt_nxt = CNT_ZERO;
                bit_cnt_nxt  = 4'd0;
            end
        endcase
    end

    // Byte-valid flag: completion wins over a same-cycle ack; a new start bit also clears it.
    always_comb begin
        rdy_nxt = rdy;
        if (frame_done) begin
            rdy_nxt = 1'b1;
        end else if (clr_rdy || start_det) begin
            rdy_nxt = 1'b0;
        end
    end

    // FSM state, bit timing and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= CNT_ZERO;
            bit_cnt  <= 4'd0;
            shifter  <= 9'h1FF;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shifter  <= shifter_nxt;
        end
    end

    // Output byte and its valid flag; rx_data only changes when a frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data <= 8'h00;
            rdy     <= 1'b0;
        end else begin
            rx_data <= rx_data_nxt;
            rdy     <= rdy_nxt;
        end
    end

`ifdef UART_RX_FRAMING_ERR_EN
    logic framing_err_nxt;

    // Stop-bit status follows each completed frame and is acked together with rdy.
    always_comb begin
        framing_err_nxt = framing_err;
        if (frame_done) begin
            framing_err_nxt = ~rx_ff2;
        end else if (clr_rdy) begin
            framing_err_nxt = 1'b0;
        end
    end

    // Framing error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            framing_err <= 1'b0;
        end else begin
            framing_err <= framing_err_nxt;
        end
    end
`endif

endmodule
